// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and iterative shift-add MUL / restoring DIV.
// Optional macro ALU_SRA_EN enables opcode 1101 as an arithmetic right shift.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rda,
    input  logic [WIDTH-1:0] rdx,
    input  logic [3:0]       alu_decode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b1010;
    localparam logic [3:0] OP_SRL = 4'b1011;
    localparam logic [3:0] OP_SLT = 4'b1100;
`ifdef ALU_SRA_EN
    localparam logic [3:0] OP_SRA = 4'b1101;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   rem_shift;
    logic             q_bit;

    // Single-cycle operations; returns {err, result}.
    function automatic logic [WIDTH:0] calc(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [3:0]       op);
        logic [WIDTH-1:0] res;
        logic             e;
        res = '0;
        e   = 1'b0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_XOR: res = a ^ b;
            OP_SLL: res = a << b[SHW-1:0];
            OP_SRL: res = a >> b[SHW-1:0];
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SRA_EN
            OP_SRA: res = $signed(a) >>> b[SHW-1:0];
`endif
            default: begin
                res = '0;
                e   = 1'b1;
            end
        endcase
        return {e, res};
    endfunction

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        rem_shift   = {acc_q, a_q[WIDTH-1]};
        q_bit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = rda;
                    b_d   = rdx;
                    acc_d = '0;
                    cnt_d = '0;
                    if (alu_decode == OP_MUL) begin
                        state_d = MUL;
                    end else if (alu_decode == OP_DIV) begin
                        state_d = DIV;
                    end else begin
                        {err_d, result_d} = calc(rda, rdx, alu_decode);
                        out_valid_d       = 1'b1;
                        state_d           = DONE;
                    end
                end
            end

            // a_q is the shifting multiplicand, b_q the shifting multiplier.
            MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d    = acc_d;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            // a_q shifts the dividend out and the quotient in; acc_q is the remainder.
            // A zero divisor always subtracts, which yields an all-ones quotient.
            DIV: begin
                if (rem_shift >= {1'b0, b_q}) begin
                    acc_d = rem_shift[WIDTH-1:0] - b_q;
                    q_bit = 1'b1;
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                end
                a_d   = {a_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d    = a_d;
                    err_d       = (b_q == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == MUL) || (state_d == DIV);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=32) against a plain-arithmetic reference model.
// Honours ALU_SRA_EN the same way as the design.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  rda;
    logic [W-1:0]  rdx;
    logic [3:0]    alu_decode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rda        (rda),
        .rdx        (rdx),
        .alu_decode (alu_decode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .err        (err),
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: result, error flag and accept-to-valid latency in cycles.
    function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] res, output logic e, output int lat);
        logic [63:0] prod;
        int          sh;
        sh   = int'(b[4:0]);
        res  = '0;
        e    = 1'b0;
        lat  = 1;
        prod = '0;
        case (op)
            4'd1:  res = a + b;
            4'd2:  res = a - b;
            4'd5: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = prod[W-1:0];
                lat  = W + 1;
            end
            4'd6: begin
                lat = W + 1;
                if (b == 0) begin
                    res = '1;
                    e   = 1'b1;
                end else begin
                    res = a / b;
                end
            end
            4'd7:  res = a | b;
            4'd8:  res = a & b;
            4'd9:  res = a ^ b;
            4'd10: res = a << sh;
            4'd11: res = a >> sh;
            4'd12: res = ($signed(a) < $signed(b)) ? 1 : 0;
`ifdef ALU_SRA_EN
            4'd13: res = $signed(a) >>> sh;
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Issues one operation, tracks latency/busy, optionally stalls the result for 'hold' cycles.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int hold);
        logic [W-1:0] expRes;
        logic         expErr;
        int           expLat;
        int           lat;
        int           busyCycles;
        int           readyCycles;
        bit           stable;
        bit           isLong;
        refModel(op, a, b, expRes, expErr, expLat);
        isLong      = (op == 4'd5) || (op == 4'd6);
        out_ready   = (hold == 0);
        checkOutput("in_ready_idle", in_ready, 1);
        in_valid    = 1'b1;
        alu_decode  = op;
        rda         = a;
        rdx         = b;
        @(posedge clk);
        #1;
        lat         = 1;
        busyCycles  = 0;
        readyCycles = 0;
        forever begin
            if (busy) busyCycles++;
            if (in_ready) readyCycles++;
            if (out_valid || lat > W + 5) break;
            in_valid   = 1'($urandom_range(0, 1));
            rda        = $urandom;
            rdx        = $urandom;
            alu_decode = 4'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("out_valid", out_valid, 1);
        checkOutput("result", result, expRes);
        checkOutput("err", err, expErr);
        checkOutput("latency", lat, expLat);
        checkOutput("busy_cycles", busyCycles, isLong ? W : 0);
        checkOutput("in_ready_busy", readyCycles, 0);
        if (!out_valid) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
            return;
        end
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                in_valid   = 1'($urandom_range(0, 1));
                rda        = $urandom;
                rdx        = $urandom;
                alu_decode = 4'($urandom);
                @(posedge clk);
                #1;
                if (result !== expRes || err !== expErr || out_valid !== 1'b1 || in_ready !== 1'b0)
                    stable = 1'b0;
            end
            checkOutput("hold_stable", stable, 1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid_cleared", out_valid, 0);
        checkOutput("in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic [3:0] rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit aborted;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        rda        = '0;
        rdx        = '0;
        alu_decode = '0;
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(4'd1, 32'd5, 32'd3, 0);

        // Abort a multiply with reset part-way through.
        in_valid   = 1'b1;
        alu_decode = 4'd5;
        rda        = 32'd5;
        rdx        = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) aborted = 1'b1;
        end
        checkOutput("abort_no_result", aborted, 0);
        checkOutput("abort_in_ready_after", in_ready, 1);

        applyStimulus(4'd2,  32'd5,        32'd3,  0);
        applyStimulus(4'd7,  32'h55,       32'hAA, 0);
        applyStimulus(4'd8,  32'h55,       32'hAA, 1);
        applyStimulus(4'd9,  32'h55,       32'hAA, 5);
        applyStimulus(4'd10, 32'h80000000, 32'd16, 0);
        applyStimulus(4'd11, 32'h12345678, 32'd1,  0);
        applyStimulus(4'd11, 32'h00F0F0F0, 32'd5,  2);
        applyStimulus(4'd12, 32'hFFFFFFFF, 32'd1,  0);
        applyStimulus(4'd12, 32'd1,        32'hFFFFFFFF, 0);
        applyStimulus(4'd10, 32'h1,        32'hFFFFFFE3, 0);
        applyStimulus(4'd5,  32'd5,        32'd3,  0);
        applyStimulus(4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        applyStimulus(4'd6,  32'd10,       32'd2,  0);
        applyStimulus(4'd6,  32'hFFFFFFFF, 32'd7,  0);
        applyStimulus(4'd6,  32'd9,        32'd0,  4);
        applyStimulus(4'd6,  32'd3,        32'd9,  0);
        applyStimulus(4'd3,  32'd1,        32'd2,  0);
        applyStimulus(4'd13, 32'h80000000, 32'd4,  0);
        applyStimulus(4'd0,  32'd7,        32'd7,  1);
        applyStimulus(4'd1,  32'hFFFFFFFF, 32'd1,  0);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom);
            if (i % 3 == 0) rop = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = W'($urandom_range(0, 7));
                1:       rb = W'($urandom_range(0, 65535));
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
